// File: rtl/keccak_cust5_resp.sv
`default_nettype none
// ============================================================================
// Module      : keccak_cust5_resp
// Description : l.cust5 Keccak command responder. Packs absorb words into
//               64-bit lanes, pads the message and serves digest readout.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_cust5_resp #(
    parameter int          MAX_WORDS = 34,
    parameter logic [31:0] PAD_WORD  = 32'h0000_0006
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [4:0]   cmd_op,
    input  logic [5:0]   cmd_limm,
    input  logic [31:0]  cmd_a,
    output logic         res_valid,
    output logic [31:0]  res_data,
    output logic         busy,
    output logic         err,
    output logic         lane_valid,
    input  logic         lane_ready,
    output logic [63:0]  lane_data,
    output logic         lane_last,
    output logic         core_clear,
    input  logic         core_done,
    input  logic [511:0] core_digest
);

    localparam int         CNT_W       = $clog2(MAX_WORDS + 1);
    localparam logic [4:0] c_op_start  = 5'b00100;
    localparam logic [4:0] c_op_middle = 5'b00010;
    localparam logic [4:0] c_op_end    = 5'b00001;
    localparam logic [4:0] c_op_read   = 5'b01000;
    localparam logic [4:0] c_op_clear  = 5'b00000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABSORB = 3'd1,
        S_SEND   = 3'd2,
        S_PAD    = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            r_after;
    state_t            w_after_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_lo;
    logic [63:0]       r_lane;
    logic              r_lane_last;
    logic              r_err;
    logic              r_core_clear;
    logic              r_res_valid;
    logic [31:0]       r_res_data;
    logic [31:0]       r_digest [16];

    logic w_start;
    logic w_absorb;
    logic w_read;
    logic w_clear;
    logic w_capture;
    logic w_proto_err;
    logic w_load_pad;
    logic w_full;
    logic w_is_end;
    logic w_clear_req;

    assign w_full      = (r_cnt == CNT_W'(MAX_WORDS));
    assign w_is_end    = (cmd_op == c_op_end);
    assign w_clear_req = cmd_valid && (cmd_op == c_op_clear);

    assign lane_valid = (r_state == S_SEND);
    assign lane_data  = r_lane;
    assign lane_last  = lane_valid & r_lane_last;
    assign busy       = (r_state != S_IDLE);
    assign err        = r_err;
    assign core_clear = r_core_clear;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_after <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_after <= w_after_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_after_nxt = r_after;
        cmd_ready   = 1'b0;
        w_start     = 1'b0;
        w_absorb    = 1'b0;
        w_read      = 1'b0;
        w_clear     = 1'b0;
        w_capture   = 1'b0;
        w_proto_err = 1'b0;
        w_load_pad  = 1'b0;
        if (w_clear_req) begin
            // Clear pre-empts everything, including a coincident core_done.
            cmd_ready   = 1'b1;
            w_clear     = 1'b1;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready = 1'b1;
                        case (cmd_op)
                            c_op_start:           begin w_start = 1'b1; w_state_nxt = S_ABSORB; end
                            c_op_middle, c_op_end: w_proto_err = 1'b1;
                            c_op_read:            w_read = 1'b1;
                            default:              ;
                        endcase
                    end
                end
                S_ABSORB: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            c_op_start: begin
                                cmd_ready   = 1'b1;
                                w_start     = 1'b1;
                                w_proto_err = 1'b1;
                            end
                            c_op_middle, c_op_end: begin
                                cmd_ready = 1'b1;
                                w_absorb  = 1'b1;
                                if (w_full) begin
                                    w_proto_err = 1'b1;
                                    if (w_is_end) w_state_nxt = S_PAD;
                                end else if (r_cnt[0] || w_is_end) begin
                                    w_state_nxt = S_SEND;
                                    if (!w_is_end)    w_after_nxt = S_ABSORB;
                                    else if (r_cnt[0]) w_after_nxt = S_PAD;
                                    else              w_after_nxt = S_WAIT;
                                end
                            end
                            c_op_read: ;
                            default:   cmd_ready = 1'b1;
                        endcase
                    end
                end
                S_SEND: begin
                    if (lane_ready) w_state_nxt = r_after;
                end
                S_PAD: begin
                    w_load_pad  = 1'b1;
                    w_state_nxt = S_SEND;
                    w_after_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_lo         <= '0;
            r_lane       <= '0;
            r_lane_last  <= 1'b0;
            r_err        <= 1'b0;
            r_core_clear <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            for (int i = 0; i < 16; i++) r_digest[i] <= '0;
        end else begin
            r_core_clear <= w_start | w_clear;
            r_res_valid  <= w_read;
            if (w_read) begin
                r_res_data <= (cmd_limm < 6'd16) ? r_digest[cmd_limm[3:0]] : 32'h0;
            end
            if (w_clear) begin
                r_cnt       <= '0;
                r_lo        <= '0;
                r_lane      <= '0;
                r_lane_last <= 1'b0;
                r_err       <= 1'b0;
                for (int i = 0; i < 16; i++) r_digest[i] <= '0;
            end else if (w_start) begin
                r_cnt       <= CNT_W'(1);
                r_lo        <= cmd_a;
                r_lane_last <= 1'b0;
                r_err       <= w_proto_err;
                for (int i = 0; i < 16; i++) r_digest[i] <= '0;
            end else begin
                if (w_proto_err) r_err <= 1'b1;
                // Words past MAX_WORDS are dropped; only the flag records them.
                if (w_absorb && !w_full) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!r_cnt[0]) begin
                        r_lo <= cmd_a;
                        if (w_is_end) begin
                            r_lane      <= {PAD_WORD, cmd_a};
                            r_lane_last <= 1'b1;
                        end
                    end else begin
                        r_lane      <= {cmd_a, r_lo};
                        r_lane_last <= 1'b0;
                    end
                end
                if (w_load_pad) begin
                    r_lane      <= {32'h0, PAD_WORD};
                    r_lane_last <= 1'b1;
                end
                if (w_capture) begin
                    for (int i = 0; i < 16; i++) r_digest[i] <= core_digest[32*i +: 32];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_cust5_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_cust5_resp
// Description : Scoreboard bench for keccak_cust5_resp lane and readout paths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_cust5_resp;

    localparam logic [4:0] c_op_start  = 5'b00100;
    localparam logic [4:0] c_op_middle = 5'b00010;
    localparam logic [4:0] c_op_end    = 5'b00001;
    localparam logic [4:0] c_op_read   = 5'b01000;
    localparam logic [4:0] c_op_clear  = 5'b00000;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd_op;
    logic [5:0]   cmd_limm;
    logic [31:0]  cmd_a;
    logic         res_valid;
    logic [31:0]  res_data;
    logic         busy;
    logic         err;
    logic         lane_valid;
    logic         lane_ready;
    logic [63:0]  lane_data;
    logic         lane_last;
    logic         core_clear;
    logic         core_done;
    logic [511:0] core_digest;

    always #5 clk = ~clk;

    keccak_cust5_resp dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_limm   (cmd_limm),
        .cmd_a      (cmd_a),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .busy       (busy),
        .err        (err),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .lane_data  (lane_data),
        .lane_last  (lane_last),
        .core_clear (core_clear),
        .core_done  (core_done),
        .core_digest(core_digest)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_lanes  = 0;
    int          n_clr    = 0;
    logic [64:0] lane_q [$];
    logic [31:0] rd_q [$];
    logic [511:0] dg;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every handshaken lane and every read result is popped here.
    always @(negedge clk) begin
        if (core_clear) n_clr++;
        if (lane_valid && lane_ready) begin
            n_lanes++;
            if (lane_q.size() == 0) check("lane_unexpected", 65'(lane_q.size()), 65'd1);
            else                    check("lane", {lane_last, lane_data}, lane_q.pop_front());
        end
        if (res_valid) begin
            if (rd_q.size() == 0) check("res_unexpected", 65'(rd_q.size()), 65'd1);
            else                  check("res_data", 65'(res_data), 65'(rd_q.pop_front()));
        end
    end

    task automatic wait_accept();
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            n++;
        end
        if (!ok) check("accept_timeout", 65'(ok), 65'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] a);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_limm  = limm;
        cmd_a     = a;
        wait_accept();
    endtask

    task automatic do_read(input logic [5:0] limm, input logic [31:0] exp);
        rd_q.push_back(exp);
        do_cmd(c_op_read, limm, 32'h0);
        check("res_valid_latency", 65'(res_valid), 65'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((lane_q.size() != 0 || lane_valid) && n < 200);
        if (lane_q.size() != 0 || lane_valid) check("drain_timeout", 65'(lane_q.size()), 65'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_done(input logic [511:0] d);
        core_digest = d;
        core_done   = 1'b1;
        @(posedge clk); #1;
        core_done   = 1'b0;
    endtask

    initial begin
        int n0;
        int c0;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_limm = '0; cmd_a = '0;
        lane_ready = 1'b1; core_done = 1'b0; core_digest = '0;
        #12;
        check("rst_lane_valid", 65'(lane_valid), 65'd0);
        check("rst_busy", 65'(busy), 65'd0);
        check("rst_err", 65'(err), 65'd0);
        check("rst_res_valid", 65'(res_valid), 65'd0);
        check("rst_core_clear", 65'(core_clear), 65'd0);
        check("rst_lane_data", 65'(lane_data), 65'd0);
        check("rst_cmd_ready", 65'(cmd_ready), 65'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 7-word message, odd total: pad shares the final lane
        c0 = n_clr;
        lane_q.push_back(65'h0_00000002_00000001);
        lane_q.push_back(65'h0_00000004_00000003);
        lane_q.push_back(65'h0_00000006_00000005);
        lane_q.push_back(65'h1_00000006_00000007);
        do_cmd(c_op_start, 6'd0, 32'd1);
        check("start_busy", 65'(busy), 65'd1);
        for (int w = 2; w <= 6; w++) do_cmd(c_op_middle, 6'd0, 32'(w));
        do_cmd(c_op_end, 6'd0, 32'd7);
        wait_drain();
        check("wait_busy", 65'(busy), 65'd1);
        check("core_clear_count", 65'(n_clr - c0), 65'd1);
        for (int i = 0; i < 16; i++) dg[32*i +: 32] = 32'h1000 + 32'(i);
        pulse_done(dg);
        check("done_busy", 65'(busy), 65'd0);
        for (int i = 15; i >= 0; i--) do_read(6'(i), 32'h1000 + 32'(i));
        do_read(6'd20, 32'h0);

        // 2-word message, even total: extra pad lane
        lane_q.push_back(65'h0_0000000B_0000000A);
        lane_q.push_back(65'h1_00000000_00000006);
        do_cmd(c_op_start, 6'd0, 32'hA);
        do_cmd(c_op_end, 6'd0, 32'hB);
        wait_drain();
        for (int i = 0; i < 16; i++) dg[32*i +: 32] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        pulse_done(dg);
        do_read(6'd9, (32'd9 * 32'h0101_0101) ^ 32'hA5A5_0000);

        // Backpressure on a lane
        lane_ready = 1'b0;
        lane_q.push_back(65'h0_00000022_00000011);
        do_cmd(c_op_start, 6'd0, 32'h11);
        do_cmd(c_op_middle, 6'd0, 32'h22);
        cmd_valid = 1'b1; cmd_op = c_op_middle; cmd_a = 32'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", 65'(cmd_ready), 65'd0);
            check("bp_lane_valid", 65'(lane_valid), 65'd1);
            check("bp_lane_data", 65'(lane_data), 65'h0_00000022_00000011);
        end
        @(posedge clk); #1;
        lane_ready = 1'b1;
        lane_q.push_back(65'h0_00000044_00000033);
        lane_q.push_back(65'h1_00000000_00000006);
        wait_accept();
        do_cmd(c_op_end, 6'd0, 32'h44);
        wait_drain();

        // Read issued while waiting for the core
        cmd_valid = 1'b1; cmd_op = c_op_read; cmd_limm = 6'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wait_read_stall", 65'(cmd_ready), 65'd0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) dg[32*i +: 32] = 32'hC0DE_0000 + 32'(i * 7);
        rd_q.push_back(32'hC0DE_0000 + 32'd21);
        core_digest = dg;
        core_done   = 1'b1;
        @(negedge clk);
        check("wait_read_stall_done", 65'(cmd_ready), 65'd0);
        @(posedge clk); #1;
        core_done = 1'b0;
        wait_accept();
        check("wait_read_res_valid", 65'(res_valid), 65'd1);

        // Protocol errors and overflow
        check("err_clean", 65'(err), 65'd0);
        do_cmd(c_op_middle, 6'd0, 32'h99);
        check("middle_idle_err", 65'(err), 65'd1);
        check("middle_idle_busy", 65'(busy), 65'd0);
        do_cmd(c_op_start, 6'd0, 32'd1);
        check("start_clears_err", 65'(err), 65'd0);
        n0 = n_lanes;
        for (int k = 0; k < 17; k++) lane_q.push_back({1'b0, 32'(2*k + 2), 32'(2*k + 1)});
        lane_q.push_back(65'h1_00000000_00000006);
        for (int w = 2; w <= 34; w++) do_cmd(c_op_middle, 6'd0, 32'(w));
        do_cmd(c_op_end, 6'd0, 32'd35);
        wait_drain();
        check("overflow_err", 65'(err), 65'd1);
        check("overflow_lanes", 65'(n_lanes - n0), 65'd18);
        pulse_done(dg);
        do_cmd(c_op_start, 6'd0, 32'h77);
        check("restart_clears_err", 65'(err), 65'd0);
        do_cmd(c_op_start, 6'd0, 32'h70);
        check("start_in_absorb_err", 65'(err), 65'd1);
        lane_q.push_back(65'h0_00000088_00000070);
        lane_q.push_back(65'h1_00000000_00000006);
        do_cmd(c_op_end, 6'd0, 32'h88);
        wait_drain();

        // Clear and core_done in the same cycle
        c0 = n_clr;
        core_digest = {16{32'hDEAD_BEEF}};
        core_done   = 1'b1;
        do_cmd(c_op_clear, 6'd0, 32'h0);
        core_done   = 1'b0;
        check("clear_core_clear", 65'(core_clear), 65'd1);
        check("clear_busy", 65'(busy), 65'd0);
        check("clear_err", 65'(err), 65'd0);
        do_read(6'd0, 32'h0);
        do_read(6'd12, 32'h0);
        check("clear_pulse_count", 65'(n_clr - c0), 65'd1);

        // Asynchronous reset while a lane is offered
        lane_ready = 1'b0;
        do_cmd(c_op_start, 6'd0, 32'h5);
        do_cmd(c_op_middle, 6'd0, 32'h6);
        @(negedge clk);
        check("pre_rst_lane_valid", 65'(lane_valid), 65'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_lane_valid", 65'(lane_valid), 65'd0);
        check("async_rst_busy", 65'(busy), 65'd0);
        check("async_rst_lane_data", 65'(lane_data), 65'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        lane_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_lane_valid", 65'(lane_valid), 65'd0);

        check("lane_q_left", 65'(lane_q.size()), 65'd0);
        check("rd_q_left", 65'(rd_q.size()), 65'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
